potential_decay_array: RTL and testbench
========================================

POTENTIAL_DECAY_ARRAY -- requirements
Module: potential_decay_array

Interface
REQ-001 SHALL have parameter NUM_NEURONS, default 30: neuron count held in the block.
REQ-002 SHALL have parameter ADDR_W, default $clog2(NUM_NEURONS): neuron address width.
REQ-003 SHALL have parameter RESET_POTENTIAL, default 32'h0000_0000: potential loaded into every neuron on reset.
REQ-004 SHALL have these ports, one clock; reset is asynchronous and active-high:
- CLK  in  1  clock.
- RST  in  1  asynchronous active-high reset.
- cfg_we  in  1  write of the decay rate and initial potential for cfg_addr.
- cfg_addr  in  ADDR_W  neuron being configured.
- cfg_decay_rate  in  4  rate code.
- cfg_potential  in  32  IEEE-754 single initial potential.
- pot_in_valid  in  1  potential update from the adder.
- pot_in_ready  out  1  update accepted; equals ~busy.
- pot_in_addr  in  ADDR_W  neuron being updated.
- pot_in_data  in  32  new potential, IEEE-754 single.
- start  in  1  timestep pulse that starts the decay sweep.
- out_valid  out  1  decayed potential present.
- out_ready  in  1  consumer accepts the output.
- out_addr  out  ADDR_W  neuron index of the output.
- out_potential  out  32  decayed potential.
- busy  out  1  sweep in progress.
- done  out  1  one-cycle pulse after the last neuron is accepted.

Function
REQ-005 SHALL keep a 32-bit potential and a 4-bit rate for each neuron.
REQ-006 SHALL apply these rate codes:
- 0001: x1.
- 0010: x1/2.
- 0100: x1/4.
- 1000: x1/8.
- 0011: x3/4 (see REQ-023).
- Any other code: x1.
REQ-007 SHALL divide by 2^k by subtracting k from the exponent; sign and mantissa pass through unchanged.
REQ-008 SHALL flush the result to signed zero if exponent <= k; denormal inputs are also flushed to signed zero.
REQ-009 SHALL pass zero, Inf and NaN inputs through unchanged.
REQ-010 SHALL have FSM states IDLE, SWEEP, DONE.
REQ-011 In IDLE, SHALL write cfg_we and accepted pot_in (valid & ready) to the addressed neuron in the same cycle; cfg_we has priority if both target one address.
REQ-012 SHALL ignore addresses >= NUM_NEURONS on cfg and pot_in.
REQ-013 On start in IDLE, SHALL go to SWEEP, clear the index to 0 and assert busy from the next cycle.
REQ-014 SHALL ignore start in SWEEP or DONE.
REQ-015 In SWEEP, when out_valid=0 or out_ready=1, SHALL in one cycle: decay mem[idx], write it back, register it on out_potential/out_addr, set out_valid, and increment idx.
REQ-016 SHALL hold out_valid, out_addr and out_potential stable while out_valid=1 and out_ready=0; no writeback or advance occurs during the stall.
REQ-017 Latency SHALL be 1 cycle from index issue to out_valid; throughput one neuron per cycle without backpressure.
REQ-018 After issuing idx = NUM_NEURONS-1, SHALL stop issuing; when that output is accepted it SHALL enter DONE, pulse done for 1 cycle and return to IDLE; idx does not wrap.
REQ-019 SHALL ignore cfg_we and pot_in while busy; pot_in_ready=0.

Reset
REQ-020 On RST=1, asynchronously: state IDLE, idx 0, all potentials = RESET_POTENTIAL, all rates = 0001.
REQ-021 On RST=1, asynchronously: out_valid, busy, done = 0; out_addr = 0; out_potential = 0.
REQ-022 RST mid-sweep SHALL abort the sweep without a done pulse; no partial writeback survives.

Configuration
REQ-023 With DECAY_THREE_QUARTER_EN defined, rate 0011 SHALL compute 3*(1.m) with the exponent adjusted by -2, normalise 1 or 2 positions, truncate, and apply REQ-008 underflow; without it, 0011 SHALL behave as x1.

Structure
REQ-024 Package potential_decay_pkg SHALL hold:
- Rate code constants.
- The FSM state enum.
- Float field widths and positions (sign 31, exponent 30:23, mantissa 22:0).
REQ-025 SHALL use one combinational sub-module, fp_decay_scale (in: potential, rate; out: decayed potential), holding REQ-006..REQ-009 and REQ-023.

Verification
REQ-026 Neuron 0 = 0x41DED852, rate 0010, start -> out_addr 0, out_potential 0x415ED852; with rate 1000 -> 0x405ED852.
REQ-027 DECAY_THREE_QUARTER_EN defined, 0x40800000 (4.0) with rate 0011 -> 0x40400000 (3.0); undefined -> 0x40800000.
REQ-028 0x00800000 with rate 0100 -> 0x00000000; 0x80800000 with rate 0010 -> 0x80000000; 0x7F800000 with rate 1000 -> 0x7F800000.
REQ-029 NUM_NEURONS=4, out_ready held low 3 cycles at neuron 1 -> output stable, no idx advance; first done pulse 1 cycle after neuron 3 is accepted; second start -> each value decayed once more.
REQ-030 start during SWEEP -> ignored; pot_in during SWEEP -> pot_in_ready=0, memory unchanged.
REQ-031 RST asserted mid-sweep at neuron 2 -> all outputs 0 at once, no done; next sweep reads RESET_POTENTIAL.

Source files
------------

// File: rtl/potential_decay_pkg.sv
// Shared definitions for the potential decay array: rate codes, sweep FSM states
// and IEEE-754 single-precision field layout.
// Pure declarations; no logic, no latency, no flow control.
package potential_decay_pkg;

    // Decay rate codes stored per neuron
    localparam logic [3:0] RATE_X1        = 4'b0001;
    localparam logic [3:0] RATE_HALF      = 4'b0010;
    localparam logic [3:0] RATE_QUARTER   = 4'b0100;
    localparam logic [3:0] RATE_EIGHTH    = 4'b1000;
    localparam logic [3:0] RATE_THREE_QTR = 4'b0011;

    // IEEE-754 single field positions
    localparam int FP_W        = 32;
    localparam int FP_SIGN_BIT = 31;
    localparam int FP_EXP_MSB  = 30;
    localparam int FP_EXP_LSB  = 23;
    localparam int FP_EXP_W    = 8;
    localparam int FP_MAN_MSB  = 22;
    localparam int FP_MAN_W    = 23;

    localparam logic [FP_EXP_W-1:0] FP_EXP_ALL_ONES = 8'hFF;

    // Sweep controller states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Power-of-two divide amount (exponent decrement) for a rate code.
    // Unknown codes, x1 and x3/4 map to zero here.
    function automatic logic [1:0] rate_shift(input logic [3:0] rate);
        logic [1:0] k;
        case (rate)
            RATE_HALF:    k = 2'd1;
            RATE_QUARTER: k = 2'd2;
            RATE_EIGHTH:  k = 2'd3;
            default:      k = 2'd0;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/fp_decay_scale.sv
// Scales one IEEE-754 single potential by its neuron's decay rate (x1, /2, /4, /8, optional x3/4).
// Purely combinational, zero latency; no flow control.
// Optional x3/4 path enabled by defining DECAY_THREE_QUARTER_EN; otherwise code 0011 behaves as x1.
module fp_decay_scale
    import potential_decay_pkg::*;
(
    input  logic [FP_W-1:0] potential,
    input  logic [3:0]      rate,
    output logic [FP_W-1:0] decayed
);

    logic                sign;
    logic [FP_EXP_W-1:0] expo;
    logic [FP_MAN_W-1:0] man;
    logic [1:0]          shift;
    logic [FP_W-1:0]     signed_zero;

    assign sign        = potential[FP_SIGN_BIT];
    assign expo        = potential[FP_EXP_MSB:FP_EXP_LSB];
    assign man         = potential[FP_MAN_MSB:0];
    assign shift       = rate_shift(rate);
    assign signed_zero = {sign, {(FP_W-1){1'b0}}};

`ifdef DECAY_THREE_QUARTER_EN
    // 3*(1.m) lies in [3,6): normalise by 1 (bit 24 leads) or 2 (bit 25 leads)
    // positions; combined with the /4 the exponent moves by -1 or 0.
    logic [FP_MAN_W:0]   sig;
    logic [FP_MAN_W+2:0] prod;
    logic [FP_W-1:0]     tq_result;

    assign sig  = {1'b1, man};
    assign prod = {2'b00, sig} + {1'b0, sig, 1'b0};

    // Truncating x3/4 with flush to signed zero on exponent underflow
    always_comb begin
        tq_result = signed_zero;
        if (prod[FP_MAN_W+2]) begin
            tq_result = {sign, expo, prod[FP_MAN_W+1:2]};
        end else if (expo > 8'd1) begin
            tq_result = {sign, expo - 8'd1, prod[FP_MAN_W:1]};
        end
    end
`endif

    // Special values pass through, denormals flush, normals get exponent decrement
    always_comb begin
        decayed = potential;
        if (expo == FP_EXP_ALL_ONES) begin
            decayed = potential;                    // Inf / NaN unchanged
        end else if (expo == '0) begin
            decayed = signed_zero;                  // zero kept, denormal flushed
`ifdef DECAY_THREE_QUARTER_EN
        end else if (rate == RATE_THREE_QTR) begin
            decayed = tq_result;
`endif
        end else if (expo <= {6'b0, shift}) begin
            decayed = signed_zero;                  // result would underflow
        end else begin
            decayed = {sign, expo - {6'b0, shift}, man};
        end
    end

endmodule

// File: rtl/potential_decay_array.sv
// Per-neuron potential store that, on each timestep, sweeps all neurons, decays them and streams them out.
// One cycle from index issue to out_valid; one neuron per cycle when out_ready stays high.
// out_valid/ready stall freezes output, index and writeback; updates are refused (pot_in_ready=0) while busy.
// Optional x3/4 decay rate enabled by defining DECAY_THREE_QUARTER_EN (see fp_decay_scale).
module potential_decay_array
    import potential_decay_pkg::*;
#(
    parameter int          NUM_NEURONS     = 30,
    parameter int          ADDR_W          = $clog2(NUM_NEURONS),
    parameter logic [31:0] RESET_POTENTIAL = 32'h0000_0000
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              cfg_we,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [3:0]        cfg_decay_rate,
    input  logic [31:0]       cfg_potential,
    input  logic              pot_in_valid,
    output logic              pot_in_ready,
    input  logic [ADDR_W-1:0] pot_in_addr,
    input  logic [31:0]       pot_in_data,
    input  logic              start,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [31:0]       out_potential,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_NEURONS - 1);

    state_t            state;
    logic [ADDR_W-1:0] idx;
    logic              last_issued;

    logic [31:0]       pot_mem  [NUM_NEURONS];
    logic [3:0]        rate_mem [NUM_NEURONS];

    logic [31:0]       sel_pot;
    logic [3:0]        sel_rate;
    logic [31:0]       decayed_pot;

    logic              issue;
    logic              pot_we;
    logic              cfg_wr;

    assign pot_in_ready = ~busy;

    // A slot is issued when the output register is empty or being drained,
    // and the final neuron has not yet gone out.
    assign issue  = (state == SWEEP) && !last_issued && (!out_valid || out_ready);

    // Host-side writes only land while idle.
    assign pot_we = (state == IDLE) && pot_in_valid && pot_in_ready;
    assign cfg_wr = (state == IDLE) && cfg_we && !busy;

    // Read mux for the neuron currently indexed by the sweep
    always_comb begin
        sel_pot  = '0;
        sel_rate = RATE_X1;
        for (int i = 0; i < NUM_NEURONS; i++) begin
            if (idx == ADDR_W'(i)) begin
                sel_pot  = pot_mem[i];
                sel_rate = rate_mem[i];
            end
        end
    end

    fp_decay_scale u_decay_scale (
        .potential (sel_pot),
        .rate      (sel_rate),
        .decayed   (decayed_pot)
    );

    // Neuron storage: sweep writeback, or idle-time update then config (config wins on collision).
    // Addresses at or beyond NUM_NEURONS match no entry and are dropped.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
                pot_mem[i]  <= RESET_POTENTIAL;
                rate_mem[i] <= RATE_X1;
            end
        end else begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
                if (issue && (idx == ADDR_W'(i))) begin
                    pot_mem[i] <= decayed_pot;
                end else begin
                    if (pot_we && (pot_in_addr == ADDR_W'(i))) begin
                        pot_mem[i] <= pot_in_data;
                    end
                    if (cfg_wr && (cfg_addr == ADDR_W'(i))) begin
                        pot_mem[i]  <= cfg_potential;
                        rate_mem[i] <= cfg_decay_rate;
                    end
                end
            end
        end
    end

    // Sweep controller with registered output stage and status flags
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state         <= IDLE;
            idx           <= '0;
            last_issued   <= 1'b0;
            out_valid     <= 1'b0;
            out_addr      <= '0;
            out_potential <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state       <= SWEEP;
                        idx         <= '0;
                        last_issued <= 1'b0;
                        busy        <= 1'b1;
                    end
                end
                SWEEP: begin
                    if (issue) begin
                        out_valid     <= 1'b1;
                        out_addr      <= idx;
                        out_potential <= decayed_pot;
                        // index parks on the last neuron rather than wrapping
                        if (idx == LAST_IDX) begin
                            last_issued <= 1'b1;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else if (last_issued && out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        state     <= DONE;
                        done      <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_potential_decay_array.sv
// Directed bench for potential_decay_array with four neurons and a non-zero reset potential.
// Drives inputs one time unit after the rising edge and samples outputs at the same point.
// Expected values are hand-computed constants; x3/4 expectations follow DECAY_THREE_QUARTER_EN.
module tb_potential_decay_array;

    localparam int          N      = 4;
    localparam int          AW     = 2;
    localparam logic [31:0] RST_PV = 32'h4100_0000;

`ifdef DECAY_THREE_QUARTER_EN
    localparam logic [31:0] EXP_N1_S1 = 32'h4040_0000;
    localparam logic [31:0] EXP_N1_S2 = 32'h4010_0000;
`else
    localparam logic [31:0] EXP_N1_S1 = 32'h4080_0000;
    localparam logic [31:0] EXP_N1_S2 = 32'h4080_0000;
`endif

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          cfg_we = 1'b0;
    logic [AW-1:0] cfg_addr = '0;
    logic [3:0]    cfg_decay_rate = '0;
    logic [31:0]   cfg_potential = '0;
    logic          pot_in_valid = 1'b0;
    logic          pot_in_ready;
    logic [AW-1:0] pot_in_addr = '0;
    logic [31:0]   pot_in_data = '0;
    logic          start = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [AW-1:0] out_addr;
    logic [31:0]   out_potential;
    logic          busy;
    logic          done;

    int n_checks = 0;
    int n_pass   = 0;

    potential_decay_array #(
        .NUM_NEURONS     (N),
        .ADDR_W          (AW),
        .RESET_POTENTIAL (RST_PV)
    ) dut (
        .CLK            (CLK),
        .RST            (RST),
        .cfg_we         (cfg_we),
        .cfg_addr       (cfg_addr),
        .cfg_decay_rate (cfg_decay_rate),
        .cfg_potential  (cfg_potential),
        .pot_in_valid   (pot_in_valid),
        .pot_in_ready   (pot_in_ready),
        .pot_in_addr    (pot_in_addr),
        .pot_in_data    (pot_in_data),
        .start          (start),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_addr       (out_addr),
        .out_potential  (out_potential),
        .busy           (busy),
        .done           (done)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic cfg_write(input logic [AW-1:0] a, input logic [3:0] r, input logic [31:0] p);
        cfg_we = 1'b1; cfg_addr = a; cfg_decay_rate = r; cfg_potential = p;
        step();
        cfg_we = 1'b0;
    endtask

    task automatic check_out(input string tag, input int a, input logic [31:0] p);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_addr"},  32'(out_addr),  32'(a));
        check({tag, "_pot"},   out_potential,  p);
    endtask

    // Full sweep with out_ready held high: one output per cycle, done one cycle after the last
    task automatic sweep_all(input string tag, input logic [31:0] e0, input logic [31:0] e1,
                             input logic [31:0] e2, input logic [31:0] e3);
        logic [31:0] ev [N];
        ev[0] = e0; ev[1] = e1; ev[2] = e2; ev[3] = e3;
        out_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        check({tag, "_v0"}, 32'(out_valid), 32'd0);
        for (int i = 0; i < N; i++) begin
            step();
            check_out($sformatf("%s_n%0d", tag, i), i, ev[i]);
        end
        step();
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_vend"}, 32'(out_valid), 32'd0);
        step();
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        step();
        step();
        // reset state
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_busy",  32'(busy),      32'd0);
        check("rst_done",  32'(done),      32'd0);
        check("rst_addr",  32'(out_addr),  32'd0);
        check("rst_pot",   out_potential,  32'd0);
        check("rst_ready", 32'(pot_in_ready), 32'd1);
        RST = 1'b0;
        step();

        // configuration; neuron 3 later gets its potential from pot_in
        cfg_write(2'd3, 4'b0010, 32'h1111_1111);
        // cfg and pot_in on the same address: cfg wins
        pot_in_valid = 1'b1; pot_in_addr = 2'd0; pot_in_data = 32'hDEAD_BEEF;
        cfg_write(2'd0, 4'b0010, 32'h41DE_D852);
        // cfg and pot_in on different addresses: both land
        pot_in_addr = 2'd3; pot_in_data = 32'h8080_0000;
        cfg_write(2'd1, 4'b0011, 32'h4080_0000);
        pot_in_valid = 1'b0;
        cfg_write(2'd2, 4'b0100, 32'h0080_0000);

        // sweep 1 with a three-cycle stall at neuron 1
        out_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        check("s1_busy", 32'(busy), 32'd1);
        check("s1_pot_in_ready", 32'(pot_in_ready), 32'd0);
        check("s1_v0", 32'(out_valid), 32'd0);
        step();
        check_out("s1_n0", 0, 32'h415E_D852);
        step();
        check_out("s1_n1", 1, EXP_N1_S1);
        out_ready = 1'b0;
        start = 1'b1;
        pot_in_valid = 1'b1; pot_in_addr = 2'd2; pot_in_data = 32'h3F80_0000;
        for (int c = 0; c < 3; c++) begin
            step();
            check_out($sformatf("s1_stall%0d", c), 1, EXP_N1_S1);
            check($sformatf("s1_stall_rdy%0d", c), 32'(pot_in_ready), 32'd0);
        end
        start = 1'b0;
        pot_in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        check_out("s1_n2", 2, 32'h0000_0000);
        step();
        check_out("s1_n3", 3, 32'h8000_0000);
        step();
        check("s1_done", 32'(done), 32'd1);
        check("s1_vend", 32'(out_valid), 32'd0);
        step();
        check("s1_done_pulse", 32'(done), 32'd0);
        check("s1_idle", 32'(busy), 32'd0);
        check("s1_no_restart", 32'(out_valid), 32'd0);

        // sweep 2: every neuron decayed once more, pot_in during sweep 1 left no trace
        sweep_all("s2", 32'h40DE_D852, EXP_N1_S2, 32'h0000_0000, 32'h8000_0000);

        // x1/8, Inf, x1 and an undefined code
        cfg_write(2'd0, 4'b1000, 32'h41DE_D852);
        cfg_write(2'd1, 4'b1000, 32'h7F80_0000);
        cfg_write(2'd2, 4'b0001, 32'h4080_0000);
        cfg_write(2'd3, 4'b0101, 32'hC000_0000);
        sweep_all("s3", 32'h405E_D852, 32'h7F80_0000, 32'h4080_0000, 32'hC000_0000);

        // reset mid-sweep while neuron 2 is on the output
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        step();
        check_out("s4_n2", 2, 32'h4080_0000);
        #2 RST = 1'b1;
        #1;
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_addr",  32'(out_addr),  32'd0);
        check("arst_pot",   out_potential,  32'd0);
        check("arst_busy",  32'(busy),      32'd0);
        check("arst_done",  32'(done),      32'd0);
        step();
        RST = 1'b0;
        step();
        check("post_rst_done", 32'(done), 32'd0);

        // sweep 5: all neurons hold the reset potential at rate x1
        sweep_all("s5", RST_PV, RST_PV, RST_PV, RST_PV);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
